// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants, state encoding and the byte S-box function.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam int NUM_WORDS  = 44;

   localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                        8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_DONE
   } ks_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/key_expansion_sub.sv
// Column substitution: S-box on each byte of a 32-bit column; round 0 passes the column through.
module key_expansion_sub
   import aes_pkg::*;
(
   input  logic [3:0]  round,
   input  logic [31:0] column,
   output logic [31:0] result
);

   always_comb begin
      result = column;
      if (round != 4'd0) begin
         for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = sbox(column[8*b +: 8]);
         end
      end
   end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: expands a 128-bit key into 44 words, one word per clock.
//
// state     | meaning
// ST_IDLE   | no key expanded since reset
// ST_EXPAND | writing w[idx], idx = 4..43
// ST_DONE   | all 44 words valid for the last accepted key
module key_expansion
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [3:0]   rd_round,
   output logic [127:0] round_key,
   output logic         busy,
   output logic         key_valid
);

   ks_state_e   state;
   logic [5:0]  idx;
   logic [31:0] w [NUM_WORDS];

   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] rcon_word;
   logic [31:0] rot_word;
   logic [31:0] sub_word;
   logic [31:0] w_new;

   always_comb begin
      w_prev    = '0;
      w_back    = '0;
      rcon_word = '0;
      if (idx >= 6'd4 && idx < 6'(NUM_WORDS)) begin
         w_prev    = w[idx - 6'd1];
         w_back    = w[idx - 6'd4];
         rcon_word = {RCON[idx[5:2]], 24'h0};
      end
   end

   assign rot_word = {w_prev[23:0], w_prev[31:24]};

   key_expansion_sub u_sub (
      .round  (4'b0001),
      .column (rot_word),
      .result (sub_word)
   );

   assign w_new = (idx[1:0] == 2'b00) ? (w_back ^ sub_word ^ rcon_word)
                                      : (w_back ^ w_prev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         key_valid <= 1'b0;
         for (int i = 0; i < NUM_WORDS; i++) w[i] <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  w[0]      <= key_in[127:96];
                  w[1]      <= key_in[95:64];
                  w[2]      <= key_in[63:32];
                  w[3]      <= key_in[31:0];
                  idx       <= 6'd4;
                  state     <= ST_EXPAND;
                  busy      <= 1'b1;
                  key_valid <= 1'b0;
               end
            end
            ST_EXPAND: begin
               w[idx] <= w_new;
               if (idx == 6'(NUM_WORDS - 1)) begin
                  idx       <= '0;
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  key_valid <= 1'b1;
               end else begin
                  idx <= idx + 6'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   logic [5:0] base;
   assign base = {rd_round, 2'b00};

   always_comb begin
      round_key = '0;
      if (rd_round <= 4'(NUM_ROUNDS)) begin
         round_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
      end
   end

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: FIPS-197 and all-zero key vectors plus restart/reset sequences.
module tb_key_expansion;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic [3:0]   rd_round;
   logic [127:0] round_key;
   logic         busy;
   logic         key_valid;

   int checks;
   int errors;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_KEY = 128'h0;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   key_expansion dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .rd_round  (rd_round),
      .round_key (round_key),
      .busy      (busy),
      .key_valid (key_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   rd;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic read_round(input logic [3:0] r, output logic [127:0] v);
      rd_round = r;
      #1;
      v = round_key;
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Leaves time at 1 unit after the accepting edge; key_in is scrambled afterwards.
   task automatic start_key(input logic [127:0] k);
      @(negedge clk);
      key_in = k;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_valid(output int cyc, output logic busy_ok);
      cyc     = 0;
      busy_ok = 1'b1;
      while (!key_valid && cyc < 60) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      logic [127:0] v;
      logic [127:0] cur_key;
      logic         have_key;
      logic         busy_ok;
      int           cyc;

      checks   = 0;
      errors   = 0;
      start    = 1'b0;
      key_in   = '0;
      rd_round = '0;
      rst      = 1'b0;

      vecs[0] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
      vecs[1] = '{FIPS_KEY, 4'd1,  FIPS_R1};
      vecs[2] = '{FIPS_KEY, 4'd10, FIPS_R10};
      vecs[3] = '{FIPS_KEY, 4'd11, 128'h0};
      vecs[4] = '{FIPS_KEY, 4'd15, 128'h0};
      vecs[5] = '{ZERO_KEY, 4'd0,  ZERO_KEY};
      vecs[6] = '{ZERO_KEY, 4'd1,  ZERO_R1};
      vecs[7] = '{ZERO_KEY, 4'd10, ZERO_R10};
      vecs[8] = '{ZERO_KEY, 4'd12, 128'h0};
      vecs[9] = '{FIPS_KEY, 4'd10, FIPS_R10};

      do_reset();
      chk("reset_busy", {127'h0, busy}, 128'h0);
      chk("reset_valid", {127'h0, key_valid}, 128'h0);
      for (int r = 0; r < 16; r++) begin
         read_round(4'(r), v);
         chk($sformatf("reset_round_%0d", r), v, 128'h0);
      end

      have_key = 1'b0;
      cur_key  = '0;
      for (int i = 0; i < 10; i++) begin
         if (!have_key || cur_key !== vecs[i].key) begin
            start_key(vecs[i].key);
            chk("accept_busy", {127'h0, busy}, 128'h1);
            chk("accept_valid", {127'h0, key_valid}, 128'h0);
            wait_valid(cyc, busy_ok);
            chk("latency", 128'(cyc), 128'd40);
            chk("busy_during", {127'h0, busy_ok}, 128'h1);
            chk("busy_done", {127'h0, busy}, 128'h0);
            cur_key  = vecs[i].key;
            have_key = 1'b1;
         end
         read_round(vecs[i].rd, v);
         chk($sformatf("vec%0d_round_%0d", i, vecs[i].rd), v, vecs[i].exp);
      end

      // DONE holds with no start.
      repeat (5) @(posedge clk);
      #1;
      chk("done_hold", {126'h0, busy, key_valid}, 128'h1);

      // A second start during expansion must be ignored.
      start_key(FIPS_KEY);
      repeat (9) @(posedge clk);
      #1;
      start_key(ZERO_KEY);
      wait_valid(cyc, busy_ok);
      chk("ignore_latency", 128'(cyc + 10), 128'd40);
      read_round(4'd10, v);
      chk("ignore_round_10", v, FIPS_R10);
      read_round(4'd0, v);
      chk("ignore_round_0", v, FIPS_KEY);

      // Restart from DONE with the zero key.
      start_key(ZERO_KEY);
      chk("restart_valid_drop", {127'h0, key_valid}, 128'h0);
      wait_valid(cyc, busy_ok);
      chk("restart_latency", 128'(cyc), 128'd40);
      read_round(4'd1, v);
      chk("restart_round_1", v, ZERO_R1);

      // Reset in the middle of an expansion.
      start_key(FIPS_KEY);
      repeat (20) @(posedge clk);
      #3;
      rd_round = 4'd0;
      rst = 1'b1;
      #1;
      chk("midrst_busy", {127'h0, busy}, 128'h0);
      chk("midrst_valid", {127'h0, key_valid}, 128'h0);
      chk("midrst_round_0", round_key, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_stays_idle", {126'h0, busy, key_valid}, 128'h0);
      start_key(ZERO_KEY);
      wait_valid(cyc, busy_ok);
      chk("midrst_latency", 128'(cyc), 128'd40);
      read_round(4'd10, v);
      chk("midrst_round_10", v, ZERO_R10);
      read_round(4'd1, v);
      chk("midrst_round_1", v, ZERO_R1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
